// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  // HLT encoding: opcode field [15:14] and function field [7:4].
  localparam logic [1:0] HLT_OP_HI = 2'b11;
  localparam logic [3:0] HLT_OP_FN = 4'b1111;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // True when an instruction word encodes HLT.
  function automatic logic is_hlt(input logic [DATA_W-1:0] word);
    return (word[15:14] == HLT_OP_HI) && (word[7:4] == HLT_OP_FN);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, single-entry command
// register towards decode, branch redirect with drain of in-flight reads.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] COMMAND,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic              PC_load,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   command_q, command_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                halted_q, halted_d;

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    command_d   = command_q;
    pc_out_d    = pc_out_q;
    cmd_valid_d = cmd_valid_q;
    halted_d    = halted_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;

    case (state_q)
      ST_REQ: begin
        if (mem_req_q) begin
          if (PC_load) begin
            // Completed data is dropped; an incomplete read must be drained.
            fetch_pc_d = branch_target;
            state_d    = mem_ready ? ST_REQ : ST_DRAIN;
          end else if (mem_ready) begin
            command_d   = mem_rdata;
            pc_out_d    = fetch_pc_q;
            cmd_valid_d = 1'b1;
            fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
            state_d     = ST_ISSUE;
          end
        end else if (PC_load) begin
          // Bubble cycle after reset: nothing outstanding yet.
          fetch_pc_d = branch_target;
        end
      end

      ST_ISSUE: begin
        if (PC_load) begin
          cmd_valid_d = 1'b0;
          fetch_pc_d  = branch_target;
          state_d     = ST_REQ;
        end else if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          if (is_hlt(command_q)) begin
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end else begin
            state_d = ST_REQ;
          end
        end
      end

      ST_DRAIN: begin
        if (PC_load) begin
          fetch_pc_d = branch_target;
        end
        if (mem_ready) begin
          state_d = ST_REQ;
        end
      end

      ST_HALTED: begin
        cmd_valid_d = 1'b0;
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase

    // Request stays asserted with a held address until the read completes.
    mem_req_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
    if (state_d == ST_REQ) begin
      mem_addr_d = fetch_pc_d;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      fetch_pc_q  <= RESET_PC;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= RESET_PC;
      command_q   <= '0;
      pc_out_q    <= '0;
      cmd_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      command_q   <= command_d;
      pc_out_q    <= pc_out_d;
      cmd_valid_q <= cmd_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign COMMAND   = command_q;
  assign cmd_valid = cmd_valid_q;
  assign pc_out    = pc_out_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-configurable memory model and
// an expected-instruction queue compared on each accepted transfer.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] COMMAND;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        PC_load = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] pc_out;
  logic        halted;

  typedef struct packed {
    logic [15:0] cmd;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] mem [0:65535];
  int          mem_lat = 0;
  int          wait_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .COMMAND      (COMMAND),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .PC_load      (PC_load),
    .branch_target(branch_target),
    .pc_out       (pc_out),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Memory model: answers after mem_lat waiting cycles; dropping mem_req abandons the read.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt >= mem_lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
        wait_cnt  = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 16'($urandom);
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    PC_load   = 1'b0;
    cmd_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (mem_req !== 1'b0 || cmd_valid !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: mem_req=%b cmd_valid=%b halted=%b expected 0/0/0", mem_req, cmd_valid, halted);
    end
    checks++;
    if (COMMAND !== 16'h0000 || pc_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: COMMAND=%h pc_out=%h expected 0000/0000", COMMAND, pc_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_req: mem_req=%b expected 0", mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_req: mem_req=%b mem_addr=%h cmd_valid=%b expected 1/%h/0", mem_req, mem_addr, cmd_valid, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int last_cyc;
    mem_lat = 0;
    do_reset();
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back('{cmd: mem[i], pc: 16'(i)});
    last_cyc = -1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      step();
      if (cmd_valid && cmd_ready && !PC_load) begin
        e = exp_q.pop_front();
        checks++;
        if (COMMAND !== e.cmd || pc_out !== e.pc) begin
          errors++;
          $display("FAIL stream_data: COMMAND=%h pc_out=%h expected %h/%h", COMMAND, pc_out, e.cmd, e.pc);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (c - last_cyc != 2) begin
            errors++;
            $display("FAIL stream_rate: spacing=%0d cycles expected 2", c - last_cyc);
          end
        end
        last_cyc = c;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout: %0d instructions outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stall();
    mem_lat = 0;
    do_reset();
    exp_q.push_back('{cmd: mem[0], pc: 16'h0000});
    for (int c = 0; c < 10 && !cmd_valid; c++) step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || COMMAND !== exp_q[0].cmd || pc_out !== exp_q[0].pc || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: valid=%b COMMAND=%h pc_out=%h mem_req=%b expected 1/%h/%h/0",
                 cmd_valid, COMMAND, pc_out, mem_req, exp_q[0].cmd, exp_q[0].pc);
      end
      step();
    end
    cmd_ready = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (cmd_valid !== 1'b1 || COMMAND !== e.cmd || pc_out !== e.pc) begin
      errors++;
      $display("FAIL stall_accept: valid=%b COMMAND=%h pc_out=%h expected 1/%h/%h", cmd_valid, COMMAND, pc_out, e.cmd, e.pc);
    end
    exp_q.push_back('{cmd: mem[1], pc: 16'h0001});
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step();
      if (cmd_valid && cmd_ready && !PC_load) begin
        e = exp_q.pop_front();
        checks++;
        if (COMMAND !== e.cmd || pc_out !== e.pc) begin
          errors++;
          $display("FAIL stall_next: COMMAND=%h pc_out=%h expected %h/%h", COMMAND, pc_out, e.cmd, e.pc);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_timeout: %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_redirect_req();
    mem_lat = 0;
    do_reset();
    cmd_ready     = 1'b1;
    PC_load       = 1'b1;
    branch_target = 16'h0200;
    step();
    PC_load = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0200) begin
      errors++;
      $display("FAIL redir_req: valid=%b mem_req=%b mem_addr=%h expected 0/1/0200", cmd_valid, mem_req, mem_addr);
    end
    exp_q.push_back('{cmd: mem[16'h0200], pc: 16'h0200});
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step();
      if (cmd_valid && cmd_ready && !PC_load) begin
        e = exp_q.pop_front();
        checks++;
        if (COMMAND !== e.cmd || pc_out !== e.pc) begin
          errors++;
          $display("FAIL redir_req_data: COMMAND=%h pc_out=%h expected %h/%h", COMMAND, pc_out, e.cmd, e.pc);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL redir_req_timeout: %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_redirect_accept();
    mem_lat = 0;
    do_reset();
    cmd_ready = 1'b1;
    step();
    checks++;
    if (cmd_valid !== 1'b1 || pc_out !== 16'h0000) begin
      errors++;
      $display("FAIL redir_issue_pre: valid=%b pc_out=%h expected 1/0000", cmd_valid, pc_out);
    end
    PC_load       = 1'b1;
    branch_target = 16'h0100;
    step();
    PC_load = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0100) begin
      errors++;
      $display("FAIL redir_issue: valid=%b mem_req=%b mem_addr=%h expected 0/1/0100", cmd_valid, mem_req, mem_addr);
    end
    exp_q.push_back('{cmd: mem[16'h0100], pc: 16'h0100});
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step();
      if (cmd_valid && cmd_ready && !PC_load) begin
        e = exp_q.pop_front();
        checks++;
        if (COMMAND !== e.cmd || pc_out !== e.pc) begin
          errors++;
          $display("FAIL redir_issue_data: COMMAND=%h pc_out=%h expected %h/%h", COMMAND, pc_out, e.cmd, e.pc);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL redir_issue_timeout: %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_redirect_inflight();
    mem_lat = 0;
    do_reset();
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back('{cmd: mem[i], pc: 16'(i)});
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      step();
      if (cmd_valid && cmd_ready && !PC_load) begin
        e = exp_q.pop_front();
        checks++;
        if (COMMAND !== e.cmd || pc_out !== e.pc) begin
          errors++;
          $display("FAIL inflight_pre: COMMAND=%h pc_out=%h expected %h/%h", COMMAND, pc_out, e.cmd, e.pc);
        end
        if (exp_q.size() == 0) mem_lat = 3;
      end
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0005) begin
      errors++;
      $display("FAIL inflight_req: mem_req=%b mem_addr=%h expected 1/0005", mem_req, mem_addr);
    end
    PC_load       = 1'b1;
    branch_target = 16'h0040;
    step();
    PC_load = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0005 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL inflight_drain: mem_req=%b mem_addr=%h valid=%b expected 1/0005/0", mem_req, mem_addr, cmd_valid);
    end
    exp_q.push_back('{cmd: mem[16'h0040], pc: 16'h0040});
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      step();
      if (cmd_valid && cmd_ready && !PC_load) begin
        e = exp_q.pop_front();
        checks++;
        if (COMMAND !== e.cmd || pc_out !== e.pc) begin
          errors++;
          $display("FAIL inflight_target: COMMAND=%h pc_out=%h expected %h/%h", COMMAND, pc_out, e.cmd, e.pc);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL inflight_timeout: %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    mem_lat = 0;
  endtask

  task automatic test_wrap_halt();
    logic [15:0] saved;
    mem_lat = 0;
    do_reset();
    saved         = mem[0];
    mem[0]        = 16'hC0F0;
    cmd_ready     = 1'b1;
    PC_load       = 1'b1;
    branch_target = 16'hFFFF;
    step();
    PC_load = 1'b0;
    step();
    checks++;
    if (cmd_valid !== 1'b1 || COMMAND !== mem[16'hFFFF] || pc_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_top: valid=%b COMMAND=%h pc_out=%h expected 1/%h/ffff", cmd_valid, COMMAND, pc_out, mem[16'hFFFF]);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_addr: mem_req=%b mem_addr=%h expected 1/0000", mem_req, mem_addr);
    end
    exp_q.push_back('{cmd: 16'hC0F0, pc: 16'h0000});
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step();
      if (cmd_valid && cmd_ready && !PC_load) begin
        e = exp_q.pop_front();
        checks++;
        if (COMMAND !== e.cmd || pc_out !== e.pc) begin
          errors++;
          $display("FAIL halt_word: COMMAND=%h pc_out=%h expected %h/%h", COMMAND, pc_out, e.cmd, e.pc);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL halt_timeout: %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    step();
    checks++;
    if (halted !== 1'b1 || cmd_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_state: halted=%b valid=%b mem_req=%b expected 1/0/0", halted, cmd_valid, mem_req);
    end
    PC_load       = 1'b1;
    branch_target = 16'h0300;
    step();
    PC_load = 1'b0;
    repeat (3) step();
    checks++;
    if (halted !== 1'b1 || cmd_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_ignore_load: halted=%b valid=%b mem_req=%b expected 1/0/0", halted, cmd_valid, mem_req);
    end
    mem[0] = saved;
  endtask

  task automatic test_reset_drain();
    mem_lat = 0;
    do_reset();
    cmd_ready = 1'b1;
    step();
    checks++;
    if (cmd_valid !== 1'b1 || COMMAND !== mem[0] || pc_out !== 16'h0000) begin
      errors++;
      $display("FAIL rdrain_first: valid=%b COMMAND=%h pc_out=%h expected 1/%h/0000", cmd_valid, COMMAND, pc_out, mem[0]);
    end
    mem_lat = 5;
    step();
    PC_load       = 1'b1;
    branch_target = 16'h0050;
    step();
    PC_load = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0001 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdrain_drain: mem_req=%b mem_addr=%h valid=%b expected 1/0001/0", mem_req, mem_addr, cmd_valid);
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || cmd_valid !== 1'b0 || COMMAND !== 16'h0000 || pc_out !== 16'h0000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL rdrain_async: mem_req=%b valid=%b COMMAND=%h pc_out=%h halted=%b expected 0/0/0000/0000/0",
               mem_req, cmd_valid, COMMAND, pc_out, halted);
    end
    mem_lat = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rdrain_restart: mem_req=%b mem_addr=%h expected 1/%h", mem_req, mem_addr, RESET_PC);
    end
    exp_q.push_back('{cmd: mem[RESET_PC], pc: RESET_PC});
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step();
      if (cmd_valid && cmd_ready && !PC_load) begin
        e = exp_q.pop_front();
        checks++;
        if (COMMAND !== e.cmd || pc_out !== e.pc) begin
          errors++;
          $display("FAIL rdrain_data: COMMAND=%h pc_out=%h expected %h/%h", COMMAND, pc_out, e.cmd, e.pc);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rdrain_timeout: %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {2'b00, 14'(i * 7 + 3)};
    test_reset();
    test_stream();
    test_stall();
    test_redirect_req();
    test_redirect_accept();
    test_redirect_inflight();
    test_wrap_halt();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded at reset.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: mem_req  out  1  instruction-memory read request; held high until mem_ready.
REQ-005 Port: mem_addr  out  16  word address of the request; stable while mem_req high.
REQ-006 Port: mem_ready  in  1  one-cycle completion strobe; mem_rdata valid in that cycle.
REQ-007 Port: mem_rdata  in  16  instruction word from memory.
REQ-008 Port: COMMAND  out  16  registered instruction word presented to the decode unit.
REQ-009 Port: cmd_valid  out  1  COMMAND holds an unconsumed instruction.
REQ-010 Port: cmd_ready  in  1  downstream accepts COMMAND this cycle.
REQ-011 Port: PC_load  in  1  redirect request from execute (taken branch).
REQ-012 Port: branch_target  in  16  new PC; sampled when PC_load is high.
REQ-013 Port: pc_out  out  16  address of the instruction in COMMAND; used for PC-relative branch arithmetic.
REQ-014 Port: halted  out  1  high once a HLT instruction is accepted.

Function
REQ-015 Internal states: REQ, ISSUE, DRAIN, HALTED; plus a 16-bit fetch PC.
REQ-016 REQ: mem_req=1, mem_addr=fetch PC. On mem_ready: COMMAND<=mem_rdata, pc_out<=fetch PC, cmd_valid<=1, fetch PC<=fetch PC+1, next state ISSUE.
REQ-017 Minimum latency: mem_ready in cycle N -> cmd_valid high in cycle N+1.
REQ-018 ISSUE: cmd_valid=1, COMMAND and pc_out held stable until cmd_ready. On cmd_ready without PC_load: cmd_valid<=0, next state REQ.
REQ-019 A transfer is accepted when cmd_valid and cmd_ready are both high; COMMAND changes only after acceptance or redirect.
REQ-020 PC addition is modulo 2^16; 16'hFFFF increments to 16'h0000 with no flag.
REQ-021 PC_load in REQ with mem_ready=0: fetch PC<=branch_target, next state DRAIN; the outstanding request is completed, not aborted.
REQ-022 PC_load in REQ with mem_ready=1: returned data discarded, cmd_valid stays 0, fetch PC<=branch_target, stay in REQ.
REQ-023 PC_load in ISSUE, with or without cmd_ready: cmd_valid<=0, fetch PC<=branch_target, next state REQ; redirect wins over acceptance.
REQ-024 DRAIN: mem_req=1 with the old address held; on mem_ready, data discarded, next state REQ. A further PC_load in DRAIN overwrites the fetch PC; the last target wins.
REQ-025 HLT is COMMAND[15:14]==2'b11 and COMMAND[7:4]==4'b1111. Its acceptance in ISSUE (no simultaneous PC_load) -> state HALTED, cmd_valid<=0, halted<=1.
REQ-026 HALTED: mem_req=0, cmd_valid=0, PC_load ignored; only reset exits.
REQ-027 cmd_valid is never asserted in REQ, DRAIN or HALTED.

Reset
REQ-028 Reset assertion takes effect immediately, independent of clk: state=REQ, fetch PC=RESET_PC, COMMAND=16'h0000, pc_out=16'h0000, cmd_valid=0, halted=0.
REQ-029 While rst_n is low, mem_req=0. First request is issued in the cycle after release, at RESET_PC.
REQ-030 Reset during an outstanding request abandons it; a late mem_ready after release is required to be ignored by the memory model.

Structure
REQ-031 The shared package holds: the state enum, the HLT opcode constants (2'b11 and 4'b1111), and the RESET_PC default.
REQ-032 The block is a single module with no sub-modules. Any optional PC incrementer is inlined.

Verification
REQ-033 Zero-wait memory, cmd_ready=1, program at 0..3: COMMAND sequence = mem[0..3], pc_out=0,1,2,3, one instruction every 2 cycles.
REQ-034 cmd_ready=0 for 5 cycles in ISSUE: COMMAND and pc_out stable, mem_req=0, no PC advance.
REQ-035 PC_load with target 16'h0040 while a 3-cycle-latency fetch of 0x0005 is in flight: 0x0005 data dropped; next cmd_valid carries mem[0x40], pc_out=0x0040.
REQ-036 PC_load and cmd_ready in the same ISSUE cycle: instruction discarded; next fetch at the target.
REQ-037 Fetch at 16'hFFFF: next mem_addr=16'h0000. HLT word 16'hC0F0 accepted: halted=1, mem_req stays 0; a later PC_load has no effect.
REQ-038 rst_n pulsed low mid-DRAIN: outputs reset asynchronously per REQ-028; fetch restarts at RESET_PC.
